elevator_scheduler: RTL

// Car motion controller behind the login manager.
// - Accepts floor requests as keypad digits once the session is authorized.
// - Holds the requests in a pending mask and serves them in SCAN order:

---
 rtl/elevator_scheduler.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/elevator_scheduler.sv
// elevator_scheduler: SCAN-order car controller fed by keypad floor requests
// Optional feature macro: FLOOR_LOCK_EN (locked floors reject non-admin requests)
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   key_in/key_valid keypad code (0-9 digit, 1010 star, 1011 hash) and strobe
//   auth, admin     session authorized / user has admin rights
//   lock_mask       per-floor lock for non-admin users (FLOOR_LOCK_EN only)
//   floor           current floor
//   direction       1 = up, 0 = down
//   moving          car travelling between floors
//   door_open       door open at current floor
//   pending         outstanding request mask
//   req_reject      one-cycle pulse when a keypad request is dropped
module elevator_scheduler #(
   parameter int NUM_FLOORS  = 10,
   parameter int MOVE_CYCLES = 8,
   parameter int DOOR_CYCLES = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [3:0]            key_in,
   input  logic                  key_valid,
   input  logic                  auth,
   input  logic                  admin,
   input  logic [NUM_FLOORS-1:0] lock_mask,
   output logic [3:0]            floor,
   output logic                  direction,
   output logic                  moving,
   output logic                  door_open,
   output logic [NUM_FLOORS-1:0] pending,
   output logic                  req_reject
);
   typedef enum logic [1:0] {IDLE, MOVE, DOOR} state_t;
   localparam logic [3:0] NF = 4'(NUM_FLOORS);
   localparam logic [3:0] STAR = 4'b1010;
   localparam logic [3:0] HASH = 4'b1011;
   localparam logic [7:0] MT = 8'(MOVE_CYCLES - 1);
   localparam logic [7:0] DT = 8'(DOOR_CYCLES - 1);
   localparam logic [NUM_FLOORS-1:0] ONE = NUM_FLOORS'(1);
   state_t state, state_nx;
   logic [7:0] timer, timer_nx;
   logic [3:0] floor_nx;
   logic dir_nx, rej_nx, locked;
   logic [NUM_FLOORS-1:0] pend_nx, clr, set;
   // any pending request strictly beyond floor f in the given direction
   function automatic logic ahead(input logic [NUM_FLOORS-1:0] p, input logic [3:0] f, input logic up);
      return up ? |((p >> f) >> 1) : |(p & ((ONE << f) - ONE));
   endfunction
`ifdef FLOOR_LOCK_EN
   assign locked = |(lock_mask & (ONE << key_in)) & ~admin;
`else
   logic unused_lock;
   assign unused_lock = ^{lock_mask, admin};
   assign locked = 1'b0;
`endif
   always_ff @(posedge clk)
      if (rst) begin
         state      <= IDLE;
         floor      <= '0;
         direction  <= 1'b1;
         pending    <= '0;
         timer      <= '0;
         req_reject <= 1'b0;
      end else begin
         state      <= state_nx;
         floor      <= floor_nx;
         direction  <= dir_nx;
         pending    <= pend_nx;
         timer      <= timer_nx;
         req_reject <= rej_nx;
      end
   always_comb begin
      state_nx = state;
      floor_nx = floor;
      dir_nx   = direction;
      timer_nx = timer;
      clr      = '0;
      set      = '0;
      rej_nx   = 1'b0;
      if (state == IDLE) begin
         if (|(pending & (ONE << floor))) begin
            clr      = ONE << floor;
            state_nx = DOOR;
            timer_nx = DT;
         end else if (|pending) begin
            // a nonzero mask with nothing ahead must lie behind, so reversing never steps off the shaft
            dir_nx   = ahead(pending, floor, direction) ? direction : ~direction;
            state_nx = MOVE;
            timer_nx = MT;
         end
      end else if (state == MOVE) begin
         timer_nx = timer - 8'd1;
         if (timer == 8'd0) begin
            floor_nx = direction ? floor + 4'd1 : floor - 4'd1;
            if (|(pending & (ONE << floor_nx))) begin
               clr      = ONE << floor_nx;
               state_nx = DOOR;
               timer_nx = DT;
            end else if (ahead(pending, floor_nx, direction)) begin
               timer_nx = MT;
            end else begin
               state_nx = IDLE;
               timer_nx = '0;
            end
         end
      end else if (state == DOOR) begin
         timer_nx = timer - 8'd1;
         if (timer == 8'd0) begin
            state_nx = IDLE;
            timer_nx = '0;
         end
      end
      // keypad overrides the FSM's own decision for door-related keys
      if (key_valid && auth) begin
         if (key_in <= 4'd9) begin
            if (key_in >= NF || locked) begin
               rej_nx = 1'b1;
            end else if (key_in == floor && state != MOVE) begin
               state_nx = DOOR;
               timer_nx = DT;
               dir_nx   = direction;
            end else begin
               set = ONE << key_in;
            end
         end else if (key_in == STAR && state == DOOR) begin
            state_nx = DOOR;
            timer_nx = DT;
         end else if (key_in == HASH && state == DOOR) begin
            state_nx = IDLE;
            timer_nx = '0;
         end
      end
      // a key set on the same index as an FSM clear survives
      pend_nx = (pending & ~clr) | set;
   end
   always_comb begin
      moving    = state == MOVE;
      door_open = state == DOOR;
   end
endmodule
